// File: rtl/rvc_mem_wrap_ws.sv
// Instruction/data memory wrapper with per-port request/ready handshakes and wait states.
// The data port aligns byte lanes, sign-extends loads and flags range/alignment faults.
module rvc_mem_wrap_ws #(
  parameter int unsigned I_MEM_DEPTH = 1024,
  parameter int unsigned D_MEM_DEPTH = 1024,
  parameter int unsigned I_WAIT      = 0,
  parameter int unsigned D_WAIT      = 0,
  parameter logic [31:0] D_MEM_BASE  = 32'h0000_1000
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        IReq,
  input  logic [31:0] Pc,
  output logic        IReady,
  output logic [31:0] Instruction,
  input  logic        DReq,
  input  logic        DWrEn,
  input  logic [3:0]  DByteEn,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWrData,
  input  logic        DSignExt,
  output logic        DReady,
  output logic [31:0] DRdData,
  output logic        DAddrErr
);

  localparam int unsigned IAW = $clog2(I_MEM_DEPTH);
  localparam int unsigned DAW = $clog2(D_MEM_DEPTH);
  localparam logic [3:0] IWaitInit = (I_WAIT == 0) ? 4'd0 : 4'(I_WAIT - 1);
  localparam logic [3:0] DWaitInit = (D_WAIT == 0) ? 4'd0 : 4'(D_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [31:0] imem [I_MEM_DEPTH];
  logic [31:0] dmem [D_MEM_DEPTH];

  // Instruction channel
  state_e         i_state_q, i_state_d;
  logic [3:0]     i_cnt_q, i_cnt_d;
  logic [IAW-1:0] i_idx_q, i_idx_d;
  logic [31:0]    i_data_q, i_data_d;
  logic           i_accept, i_fire;

  always_comb begin
    i_accept  = IReq && (i_state_q != StWait);
    i_idx_d   = i_accept ? Pc[IAW+1:2] : i_idx_q;
    i_fire    = (i_accept && (I_WAIT == 0)) || ((i_state_q == StWait) && (i_cnt_q == 4'd0));
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    i_data_d  = i_data_q;
    if (i_accept) begin
      i_state_d = (I_WAIT == 0) ? StResp : StWait;
      i_cnt_d   = IWaitInit;
    end else if (i_state_q == StWait) begin
      if (i_cnt_q == 4'd0) i_state_d = StResp;
      else                 i_cnt_d   = i_cnt_q - 4'd1;
    end else if (i_state_q == StResp) begin
      i_state_d = StIdle;
    end
    if (i_fire) i_data_d = imem[i_idx_d];
  end

  // Data channel
  state_e      d_state_q, d_state_d;
  logic [3:0]  d_cnt_q, d_cnt_d;
  logic        d_we_q, d_we_d, d_sx_q, d_sx_d;
  logic [3:0]  d_be_q, d_be_d;
  logic [31:0] d_addr_q, d_addr_d, d_wd_q, d_wd_d;
  logic [31:0] d_rd_q, d_rd_d;
  logic        d_err_q, d_err_d;
  logic        d_accept, d_fire, d_fault, d_wr_en;
  logic [31:0] d_off, d_wsh, d_rsh, d_ld;
  logic [1:0]  d_lane;
  logic [3:0]  d_mask;
  logic [DAW-1:0] d_idx;

  always_comb begin
    d_accept = DReq && (d_state_q != StWait);
    // Access data comes straight from the inputs when the access fires on the acceptance edge.
    d_we_d   = d_accept ? DWrEn    : d_we_q;
    d_sx_d   = d_accept ? DSignExt : d_sx_q;
    d_be_d   = d_accept ? DByteEn  : d_be_q;
    d_addr_d = d_accept ? DAddr    : d_addr_q;
    d_wd_d   = d_accept ? DWrData  : d_wd_q;
    d_fire   = (d_accept && (D_WAIT == 0)) || ((d_state_q == StWait) && (d_cnt_q == 4'd0));

    d_off   = d_addr_d - D_MEM_BASE;
    d_lane  = d_addr_d[1:0];
    d_idx   = d_off[DAW+1:2];
    d_fault = (d_addr_d < D_MEM_BASE) || ({2'b00, d_off[31:2]} >= D_MEM_DEPTH) ||
              ((d_be_d == 4'b0011) && (d_lane == 2'd3)) ||
              ((d_be_d == 4'b1111) && (d_lane != 2'd0));
    d_mask  = d_be_d << d_lane;
    d_wsh   = d_wd_d << {d_lane, 3'b000};
    d_rsh   = dmem[d_idx] >> {d_lane, 3'b000};
    case (d_be_d)
      4'b0001: d_ld = {{24{d_sx_d & d_rsh[7]}}, d_rsh[7:0]};
      4'b0011: d_ld = {{16{d_sx_d & d_rsh[15]}}, d_rsh[15:0]};
      default: d_ld = d_rsh;
    endcase
    // Rst gating keeps a store from landing on an edge while reset is held.
    d_wr_en = Rst && d_fire && d_we_d && !d_fault;

    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    d_rd_d    = d_rd_q;
    d_err_d   = d_err_q;
    if (d_accept) begin
      d_state_d = (D_WAIT == 0) ? StResp : StWait;
      d_cnt_d   = DWaitInit;
    end else if (d_state_q == StWait) begin
      if (d_cnt_q == 4'd0) d_state_d = StResp;
      else                 d_cnt_d   = d_cnt_q - 4'd1;
    end else if (d_state_q == StResp) begin
      d_state_d = StIdle;
    end
    if (d_fire) begin
      d_err_d = d_fault;
      if (d_fault)     d_rd_d = 32'h0;
      else if (!d_we_d) d_rd_d = d_ld;
    end
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      i_state_q <= StIdle;
      i_cnt_q   <= 4'd0;
      i_idx_q   <= '0;
      i_data_q  <= 32'h0;
      d_state_q <= StIdle;
      d_cnt_q   <= 4'd0;
      d_we_q    <= 1'b0;
      d_sx_q    <= 1'b0;
      d_be_q    <= 4'h0;
      d_addr_q  <= 32'h0;
      d_wd_q    <= 32'h0;
      d_rd_q    <= 32'h0;
      d_err_q   <= 1'b0;
    end else begin
      i_state_q <= i_state_d;
      i_cnt_q   <= i_cnt_d;
      i_idx_q   <= i_idx_d;
      i_data_q  <= i_data_d;
      d_state_q <= d_state_d;
      d_cnt_q   <= d_cnt_d;
      d_we_q    <= d_we_d;
      d_sx_q    <= d_sx_d;
      d_be_q    <= d_be_d;
      d_addr_q  <= d_addr_d;
      d_wd_q    <= d_wd_d;
      d_rd_q    <= d_rd_d;
      d_err_q   <= d_err_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (d_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (d_mask[b]) dmem[d_idx][8*b +: 8] <= d_wsh[8*b +: 8];
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{Pc[31:IAW+2], Pc[1:0], d_off[1:0]};

  assign IReady      = (i_state_q == StResp);
  assign Instruction = i_data_q;
  assign DReady      = (d_state_q == StResp);
  assign DRdData     = d_rd_q;
  assign DAddrErr    = d_err_q;

endmodule
